tanh_deriv_seq: RTL and testbench

//  Backward-pass companion to the piecewise tanh activation: computes the local

---
 rtl/tanh_deriv_seq.sv | 95 +++++++++
 tb/tb_tanh_deriv_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/tanh_deriv_seq.sv
// Local gradient of the tanh activation, d = 1 - y^2, in signed fixed point.
// The square comes from a one-bit-per-cycle shift-add multiplier, so each result takes FRAC+1 cycles.
module tanh_deriv_seq #(
    parameter int WIDTH = 32,
    parameter int FRAC  = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_y,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_d,
    output logic             o_valid,
    input  logic             i_ready
);

    localparam int ACC_W = 2 * (FRAC + 1);
    localparam int SQ_W  = ACC_W - FRAC;
    localparam int CNT_W = $clog2(FRAC + 1);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [FRAC:0]    r_a;
    logic [ACC_W-1:0] r_acc;
    logic             r_sat;

    logic [WIDTH-1:0] w_abs;
    logic             w_in_sat;
    logic [ACC_W-1:0] w_addend;
    logic [ACC_W-1:0] w_acc_next;
    logic [WIDTH-1:0] w_sq;

    // Any magnitude bit at or above the integer-one position means |y| >= 1.0.
    // 32'h80000000 negates to itself, whose top bit still lands in that range.
    assign w_abs    = i_y[WIDTH-1] ? (WIDTH'(0) - i_y) : i_y;
    assign w_in_sat = |w_abs[WIDTH-1:FRAC];

    assign w_addend   = r_a[r_cnt] ? ({{(ACC_W-FRAC-1){1'b0}}, r_a} << r_cnt) : '0;
    assign w_acc_next = r_acc + w_addend;
    assign w_sq       = {{(WIDTH-SQ_W){1'b0}}, w_acc_next[ACC_W-1:FRAC]};

    assign o_ready = (r_state == S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_acc   <= '0;
            r_sat   <= 1'b0;
            o_d     <= '0;
            o_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_a     <= w_abs[FRAC:0];
                        r_sat   <= w_in_sat;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CNT_ONE;
                    // Saturated inputs still run every iteration so latency never depends on data.
                    if (r_cnt == LAST_CNT) begin
                        o_d     <= r_sat ? '0 : (ONE - w_sq);
                        o_valid <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tanh_deriv_seq.sv
// Directed and model-checked vectors for tanh_deriv_seq, plus backpressure and mid-calculation reset.
module tb_tanh_deriv_seq;

    typedef struct {
        logic [31:0] y;
        logic [31:0] expD;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [31:0] i_y;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] o_d;
    logic        o_valid;
    logic        i_ready;

    int numChecks;
    int numErrors;

    tanh_deriv_seq #(.WIDTH(32), .FRAC(24)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_y     (i_y),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_d     (o_d),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        numChecks++;
        if (act !== expv) begin
            numErrors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while (o_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (o_ready !== 1'b1) checkOutput({name, "_idleTimeout"}, 32'(o_ready), 32'd1);
    endtask

    // Accepts y, measures the edges until o_valid, checks latency and value, then optionally handshakes.
    task automatic applyStimulus(input logic [31:0] y, input logic [31:0] expD,
                                 input string name, input bit doHandshake);
        int lat;
        waitIdle(name);
        i_y     = y;
        i_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        i_y     = $urandom;
        checkOutput({name, "_busy"}, 32'(o_ready), 32'd0);
        lat = 0;
        while (o_valid !== 1'b1 && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checkOutput({name, "_latency"}, 32'(lat), 32'd25);
        checkOutput({name, "_d"}, o_d, expD);
        if (doHandshake) begin
            i_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            i_ready = 1'b0;
            checkOutput({name, "_validDrop"}, 32'(o_valid), 32'd0);
            checkOutput({name, "_readyBack"}, 32'(o_ready), 32'd1);
        end
    endtask

    initial begin
        vec_t        vecs[20];
        logic [31:0] a;
        logic [63:0] sq;
        logic [31:0] held;
        int          seen;

        numChecks = 0;
        numErrors = 0;

        vecs[0]  = '{32'h00000000, 32'h01000000};
        vecs[1]  = '{32'h00800000, 32'h00C00000};
        vecs[2]  = '{32'hFF800000, 32'h00C00000};
        vecs[3]  = '{32'h00C00000, 32'h00700000};
        vecs[4]  = '{32'h00400000, 32'h00F00000};
        vecs[5]  = '{32'h00000001, 32'h01000000};
        vecs[6]  = '{32'h00FFFFFF, 32'h00000002};
        vecs[7]  = '{32'hFF000001, 32'h00000002};
        vecs[8]  = '{32'h01000000, 32'h00000000};
        vecs[9]  = '{32'hFF000000, 32'h00000000};
        vecs[10] = '{32'h7FFFFFFF, 32'h00000000};
        vecs[11] = '{32'h80000000, 32'h00000000};
        for (int k = 12; k < 20; k++) begin
            a  = 32'($urandom_range(0, 32'h00FFFFFF));
            sq = (64'(a) * 64'(a)) >> 24;
            vecs[k].y    = ($urandom_range(0, 1) == 1) ? (32'd0 - a) : a;
            vecs[k].expD = 32'h01000000 - sq[31:0];
        end

        rst     = 1'b1;
        i_y     = '0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_valid", 32'(o_valid), 32'd0);
        checkOutput("reset_ready", 32'(o_ready), 32'd1);
        checkOutput("reset_d", o_d, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 20; k++) begin
            applyStimulus(vecs[k].y, vecs[k].expD, $sformatf("vec%0d", k), 1'b1);
        end

        // Backpressure: hold the result for 10 cycles while junk inputs toggle.
        applyStimulus(32'h00800000, 32'h00C00000, "bp", 1'b0);
        held = o_d;
        for (int c = 0; c < 10; c++) begin
            i_valid = c[0];
            i_y     = $urandom;
            @(posedge clk);
            @(negedge clk);
            checkOutput($sformatf("bp_valid%0d", c), 32'(o_valid), 32'd1);
            checkOutput($sformatf("bp_d%0d", c), o_d, 32'h00C00000);
            checkOutput($sformatf("bp_ready%0d", c), 32'(o_ready), 32'd0);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_ready = 1'b0;
        checkOutput("bp_release_valid", 32'(o_valid), 32'd0);
        checkOutput("bp_release_ready", 32'(o_ready), 32'd1);
        checkOutput("bp_d_kept", o_d, held);
        repeat (3) @(negedge clk);
        checkOutput("bp_not_queued", 32'(o_ready), 32'd1);

        // Reset twelve cycles into a calculation; the aborted result must never appear.
        waitIdle("abort");
        i_y     = 32'h00C00000;
        i_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i_valid = 1'b0;
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_valid", 32'(o_valid), 32'd0);
        checkOutput("abort_ready", 32'(o_ready), 32'd1);
        checkOutput("abort_d", o_d, 32'd0);
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (o_valid === 1'b1) seen++;
        end
        checkOutput("abort_no_result", 32'(seen), 32'd0);
        applyStimulus(32'h00800000, 32'h00C00000, "after_abort", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule
